// File: rtl/ifu_pkg.sv
// ---------------------------------------------------------------------------
// ifu_pkg -- shared definitions for the instruction fetch unit.
//   XLEN        : architectural word width (32)
//   NOP_INSTR   : instruction shown on out_instr when nothing is valid
//   ifu_state_e : fetch controller state encoding
//   word_align  : clears the two byte-offset bits of an address
// ---------------------------------------------------------------------------
package ifu_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_FAULT = 2'b10
    } ifu_state_e;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/ifu_fifo.sv
// ---------------------------------------------------------------------------
// ifu_fifo -- small synchronous FIFO holding fetched {instr, pc} pairs.
//   Parameters: DEPTH (power of two, 2..16), WIDTH (entry width)
//   Ports:
//     clk, rstn       clock, asynchronous active-low reset
//     flush           empties the FIFO at the next edge (wins over push/pop)
//     push, push_data write an entry (accepted when not full, or when a pop
//                     happens in the same cycle)
//     pop, pop_data   read side; pop_data is the current head
//     full, empty     occupancy flags
//     count           number of valid entries (0..DEPTH)
// ---------------------------------------------------------------------------
module ifu_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic [AW:0]      count_s;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full     = (count_r == (AW+1)'(DEPTH));
    assign empty    = (count_r == (AW+1)'(0));
    assign count    = count_r;
    assign pop_data = mem_r[rd_ptr_r];

    // Accept/occupancy decode; a push into a full FIFO is legal when a pop frees the slot.
    always_comb begin
        pop_ok_s  = pop && !empty;
        push_ok_s = push && (!full || pop_ok_s);
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_s = count_r + (AW+1)'(1);
            2'b01:   count_s = count_r - (AW+1)'(1);
            default: count_s = count_r;
        endcase
    end

    // Pointer and occupancy registers; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= (AW+1)'(0);
        end else if (flush) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= (AW+1)'(0);
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_s;
        end
    end

    // Entry storage; contents are qualified by count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_ok_s && !flush) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit -- in-order instruction fetch front end.
//   Issues sequential word fetches to instruction memory, buffers returned
//   words with their PCs in ifu_fifo and hands them to decode. A redirect
//   flushes the buffer, restarts fetch at redirect_pc and discards responses
//   to requests issued before it.
//   Parameters: RESET_PC (first fetch address), DEPTH (buffer entries and
//               in-flight limit, power of two 2..16)
//   Ports:
//     clk, rstn                       clock, asynchronous active-low reset
//     redirect_valid, redirect_pc     taken branch/jump: flush and refetch
//     imem_req_valid/addr/ready       fetch request handshake
//     imem_rsp_valid/data             in-order instruction responses
//     out_valid/ready/instr/pc        decode interface (NOP when not valid)
//     out_fault                       misaligned-fetch fault flag
//   Build option IFU_MISALIGN_TRAP_EN: a misaligned redirect enters FAULT,
//   stops fetching and raises out_fault until an aligned redirect. Without
//   it the low two redirect bits are cleared and out_fault is always 0.
// ---------------------------------------------------------------------------
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        out_fault
);

    localparam int            CW    = $clog2(DEPTH);
    localparam logic [CW+1:0] LIMIT = (CW+2)'(DEPTH);

    ifu_state_e        state_r, state_s;
    logic [XLEN-1:0]   pc_r, pc_s;
    logic [XLEN-1:0]   rsp_pc_r, rsp_pc_s;
    logic [CW:0]       in_flight_r, in_flight_s;
    logic [CW:0]       drop_r, drop_s;
    logic [XLEN-1:0]   target_s;
    logic              misalign_s;
    logic [CW+1:0]     occ_s;
    logic              req_valid_s;
    logic              req_fire_s;
    logic              push_s;
    logic              pop_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [CW:0]       fifo_count_s;
    logic [63:0]       fifo_head_s;

`ifdef IFU_MISALIGN_TRAP_EN
    assign misalign_s = redirect_pc[1] | redirect_pc[0];
    assign target_s   = redirect_pc;
    assign out_fault  = (state_r == ST_FAULT);
`else
    assign misalign_s = 1'b0;
    assign target_s   = word_align(redirect_pc);
    assign out_fault  = 1'b0;
`endif

    // Controller next state: IDLE lasts one cycle, FAULT only on a misaligned redirect.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (redirect_valid && misalign_s) begin
                    state_s = ST_FAULT;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_RUN: begin
                if (redirect_valid && misalign_s) begin
                    state_s = ST_FAULT;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_FAULT: begin
                if (redirect_valid && !misalign_s) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_FAULT;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Request gating and bookkeeping. Stale responses are still counted in
    // in_flight until they return, so the limit also covers them.
    always_comb begin
        occ_s       = {1'b0, in_flight_r} + {1'b0, fifo_count_s};
        req_valid_s = (state_r == ST_RUN) && !fifo_full_s && (occ_s < LIMIT);
        req_fire_s  = req_valid_s && imem_req_ready;

        case ({req_fire_s, imem_rsp_valid})
            2'b10:   in_flight_s = in_flight_r + (CW+1)'(1);
            2'b01:   in_flight_s = in_flight_r - (CW+1)'(1);
            default: in_flight_s = in_flight_r;
        endcase

        // On redirect every request still outstanding after this cycle is stale.
        if (redirect_valid) begin
            drop_s = in_flight_s;
        end else if (imem_rsp_valid && (drop_r != (CW+1)'(0))) begin
            drop_s = drop_r - (CW+1)'(1);
        end else begin
            drop_s = drop_r;
        end

        push_s = imem_rsp_valid && !redirect_valid && (drop_r == (CW+1)'(0));
        pop_s  = !fifo_empty_s && out_ready;

        if (redirect_valid) begin
            pc_s = target_s;
        end else if (req_fire_s) begin
            pc_s = pc_r + 32'd4;
        end else begin
            pc_s = pc_r;
        end

        // Surviving responses are sequential from the last redirect target.
        if (redirect_valid) begin
            rsp_pc_s = target_s;
        end else if (push_s) begin
            rsp_pc_s = rsp_pc_r + 32'd4;
        end else begin
            rsp_pc_s = rsp_pc_r;
        end
    end

    // Controller state registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r     <= ST_IDLE;
            pc_r        <= RESET_PC;
            rsp_pc_r    <= RESET_PC;
            in_flight_r <= (CW+1)'(0);
            drop_r      <= (CW+1)'(0);
        end else begin
            state_r     <= state_s;
            pc_r        <= pc_s;
            rsp_pc_r    <= rsp_pc_s;
            in_flight_r <= in_flight_s;
            drop_r      <= drop_s;
        end
    end

    ifu_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (redirect_valid),
        .push      (push_s),
        .push_data ({imem_rsp_data, rsp_pc_r}),
        .pop       (pop_s),
        .pop_data  (fifo_head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

    assign imem_req_valid = req_valid_s;
    assign imem_req_addr  = pc_r;
    assign out_valid      = !fifo_empty_s;
    assign out_instr      = fifo_empty_s ? NOP_INSTR : fifo_head_s[63:32];
    assign out_pc         = fifo_empty_s ? 32'h0000_0000 : fifo_head_s[31:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit -- self-checking bench for instr_fetch_unit.
// An in-order memory model answers requests; every non-stale response pushes
// its expected {instr, pc} into a scoreboard queue that is popped on each
// decode handshake. A fetch-PC model checks every request address.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rstn;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_fault;

    instr_fetch_unit #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_fault      (out_fault)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Stimulus knobs applied at the next step.
    logic        redir_v;
    logic [31:0] redir_pc;
    logic        mem_hold;
    logic        mem_rdy;
    logic        rdy;

    // Models.
    logic [32:0] pend_q [$];   // {stale, addr} outstanding at the memory
    logic [63:0] exp_q  [$];   // {instr, pc} expected at the decode port
    logic [31:0] req_log [$];
    logic [31:0] model_pc;
    logic        model_fault;
    logic        prev_stall;
    logic [31:0] prev_addr;
    int          delivered;
    int          stale_drv;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0003;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
        check_eq({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_out_instr"}, out_instr, NOP);
        check_eq({tag, "_out_pc"}, out_pc, 32'h0000_0000);
        check_eq({tag, "_out_fault"}, 32'(out_fault), 32'd0);
    endtask

    // One clock: drive inputs just after the rising edge, sample at the falling edge.
    task automatic step();
        logic [32:0] e;
        logic [63:0] x;
        @(posedge clk);
        #1;
        redirect_valid = redir_v;
        redirect_pc    = redir_pc;
        out_ready      = rdy;
        imem_req_ready = mem_rdy;
        if (redir_v) begin
            for (int i = 0; i < pend_q.size(); i++) begin
                e         = pend_q[i];
                e[32]     = 1'b1;
                pend_q[i] = e;
            end
        end
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0000_0000;
        if (rstn && !mem_hold && pend_q.size() > 0) begin
            e              = pend_q.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(e[31:0]);
            if (e[32] || redir_v) begin
                stale_drv++;
            end else begin
                exp_q.push_back({mem_word(e[31:0]), e[31:0]});
            end
        end
        @(negedge clk);
        if (rstn) begin
            check_eq("out_fault", 32'(out_fault), 32'(model_fault));
            if (model_fault) begin
                check_eq("fault_noreq", 32'(imem_req_valid), 32'd0);
            end
            if (prev_stall) begin
                check_eq("req_hold_v", 32'(imem_req_valid), 32'd1);
                check_eq("req_hold_a", imem_req_addr, prev_addr);
            end
            if (imem_req_valid && imem_req_ready) begin
                check_eq("req_addr", imem_req_addr, model_pc);
                pend_q.push_back({redir_v, imem_req_addr});
                req_log.push_back(imem_req_addr);
                model_pc = model_pc + 32'd4;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("out_extra", 32'(out_valid), 32'd0);
                end else begin
                    x = exp_q.pop_front();
                    check_eq("out_pc", out_pc, x[31:0]);
                    check_eq("out_instr", out_instr, x[63:32]);
                    delivered++;
                end
            end
            if (!out_valid) begin
                check_eq("nop_idle", out_instr, NOP);
            end
            if (redir_v) begin
                exp_q.delete();
`ifdef IFU_MISALIGN_TRAP_EN
                model_pc    = redir_pc;
                model_fault = (redir_pc[1:0] != 2'b00);
`else
                model_pc    = redir_pc & 32'hFFFF_FFFC;
                model_fault = 1'b0;
`endif
            end
            prev_stall = imem_req_valid && !imem_req_ready && !redir_v;
            prev_addr  = imem_req_addr;
        end
    endtask

    task automatic expect_next_req(input string tag, input logic [31:0] a);
        int n;
        n = 0;
        step();
        while (!(imem_req_valid && imem_req_ready) && n < 10) begin
            step();
            n++;
        end
        check_eq({tag, "_v"}, 32'(imem_req_valid && imem_req_ready), 32'd1);
        check_eq(tag, imem_req_addr, a);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int d0;
        int r0;
        rstn           = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0000_0000;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0000_0000;
        out_ready      = 1'b0;
        redir_v        = 1'b0;
        redir_pc       = 32'h0000_0000;
        mem_hold       = 1'b0;
        mem_rdy        = 1'b1;
        rdy            = 1'b0;
        model_pc       = RESET_PC;
        model_fault    = 1'b0;
        prev_stall     = 1'b0;
        prev_addr      = 32'h0000_0000;
        delivered      = 0;
        stale_drv      = 0;
        r0             = 0;

        repeat (3) step();
        check_reset("reset");
        rstn = 1'b1;

        // Start-up latency and back-pressure with decode stalled.
        step();
        check_eq("c1_out_valid", 32'(out_valid), 32'd0);
        step();
        check_eq("c2_out_valid", 32'(out_valid), 32'd0);
        step();
        check_eq("c3_out_valid", 32'(out_valid), 32'd1);
        check_eq("c3_out_pc", out_pc, RESET_PC);
        repeat (10) step();
        check_eq("stall_reqs", 32'(req_log.size()), 32'(DEPTH));
        for (int i = 0; i < 4; i++) begin
            if (req_log.size() > i) begin
                check_eq("first_reqs", req_log[i], RESET_PC + 32'(4 * i));
            end
        end
        check_eq("stall_req_valid", 32'(imem_req_valid), 32'd0);
        check_eq("stall_out_pc", out_pc, RESET_PC);
        check_eq("stall_held", 32'(exp_q.size()), 32'(DEPTH));

        rdy = 1'b1;
        repeat (10) step();

        // Redirect with three requests outstanding.
        mem_hold = 1'b1;
        n = 0;
        while (pend_q.size() < 3 && n < 20) begin
            step();
            n++;
        end
        check_eq("pend3", 32'(pend_q.size()), 32'd3);
        mem_rdy   = 1'b0;
        redir_v   = 1'b1;
        redir_pc  = 32'h0000_0040;
        stale_drv = 0;
        step();
        redir_v = 1'b0;
        mem_rdy = 1'b1;
        expect_next_req("redir40_req", 32'h0000_0040);
        mem_hold = 1'b0;
        n = 0;
        step();
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        check_eq("redir40_out_pc", out_pc, 32'h0000_0040);
        check_eq("redir40_dropped", 32'(stale_drv), 32'd3);

        // Redirect coincident with a response and a decode pop.
        repeat (6) step();
        n = 0;
        while (!(out_valid && imem_rsp_valid && pend_q.size() > 0) && n < 20) begin
            step();
            n++;
        end
        d0       = delivered;
        redir_v  = 1'b1;
        redir_pc = 32'h0000_0100;
        step();
        redir_v = 1'b0;
        check_eq("coinc_rsp", 32'(imem_rsp_valid), 32'd1);
        check_eq("coinc_pop", 32'(out_valid && out_ready), 32'd1);
        check_eq("coinc_delivered", 32'(delivered), 32'(d0 + 1));
        step();
        check_eq("coinc_req_v", 32'(imem_req_valid), 32'd1);
        check_eq("coinc_req_addr", imem_req_addr, 32'h0000_0100);
        repeat (8) step();

        // Misaligned redirect.
        redir_v  = 1'b1;
        redir_pc = 32'h0000_0042;
        step();
        redir_v = 1'b0;
`ifdef IFU_MISALIGN_TRAP_EN
        r0 = req_log.size();
        repeat (8) step();
        check_eq("mis_fault", 32'(out_fault), 32'd1);
        check_eq("mis_noreq", 32'(req_log.size()), 32'(r0));
        check_eq("mis_out_valid", 32'(out_valid), 32'd0);
        redir_v  = 1'b1;
        redir_pc = 32'h0000_0080;
        step();
        redir_v = 1'b0;
        step();
        check_eq("mis_clear", 32'(out_fault), 32'd0);
        check_eq("mis_req_v", 32'(imem_req_valid), 32'd1);
        check_eq("mis_req_addr", imem_req_addr, 32'h0000_0080);
`else
        step();
        check_eq("mis_req_v", 32'(imem_req_valid), 32'd1);
        check_eq("mis_req_addr", imem_req_addr, 32'h0000_0040);
        check_eq("mis_nofault", 32'(out_fault), 32'd0);
`endif
        repeat (8) step();

        // Fetch PC wrap through zero.
        redir_v  = 1'b1;
        redir_pc = 32'hFFFF_FFF8;
        step();
        redir_v = 1'b0;
        expect_next_req("wrap_req", 32'hFFFF_FFF8);
        repeat (10) step();
        check_eq("wrap_nofault", 32'(out_fault), 32'd0);

        // Reset with requests outstanding; memory is reset alongside.
        mem_hold = 1'b1;
        n = 0;
        while (pend_q.size() < 2 && n < 20) begin
            step();
            n++;
        end
        check_eq("pend2", 32'(pend_q.size()), 32'd2);
        rstn = 1'b0;
        pend_q.delete();
        exp_q.delete();
        model_pc    = RESET_PC;
        model_fault = 1'b0;
        prev_stall  = 1'b0;
        mem_hold    = 1'b0;
        #1;
        check_reset("rst_async");
        repeat (2) step();
        check_reset("rst_hold");
        rstn = 1'b1;
        n = 0;
        step();
        while (!out_valid && n < 10) begin
            step();
            n++;
        end
        check_eq("post_rst_valid", 32'(out_valid), 32'd1);
        check_eq("post_rst_pc", out_pc, RESET_PC);

        // Randomised back-pressure, memory stalls and aligned redirects.
        for (int k = 0; k < 200; k++) begin
            rdy      = ($urandom_range(0, 3) != 0);
            mem_rdy  = ($urandom_range(0, 3) != 0);
            mem_hold = ($urandom_range(0, 4) == 0);
            redir_v  = ((k % 23) == 22);
            if (redir_v) begin
                redir_pc = 32'($urandom_range(0, 1023)) << 2;
            end
            step();
        end
        redir_v  = 1'b0;
        rdy      = 1'b1;
        mem_rdy  = 1'b1;
        mem_hold = 1'b0;
        repeat (15) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
